// File: rtl/axiburst_pkg.sv
// axiburst_pkg: shared constants and FSM state type for the burst stream writer
package axiburst_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam int BOUNDARY = 4096;
  localparam int MAX_BURST = 16;
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WAIT_FREE, S_START, S_BEATS, S_WAIT_RESP, S_DONE
  } state_t;
endpackage

// File: rtl/axiburst_sync_fifo.sv
// axiburst_sync_fifo: show-ahead FIFO whose head already reflects a same-cycle pop
module axiburst_sync_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  // the word behind a popping head is exposed immediately; nothing left reads as zero
  assign dout = (cnt_q == (AW+1)'(pop)) ? '0 : mem_q[rd_d];
  assign count = cnt_q;
  assign full = cnt_q[AW];
endmodule

// File: rtl/axiburst_stream_writer.sv
// axiburst_stream_writer: buffers a stream and issues it as 4KB-safe write bursts
module axiburst_stream_writer
  import axiburst_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cfg_start,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [15:0]           cfg_beats,
  input  logic [DATA_W/8-1:0]   cfg_strb,
  input  logic                  s_valid,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  s_ready,
  output logic                  user_start,
  output logic [ADDR_W-1:0]     user_addr_in,
  output logic [7:0]            user_burst_len_in,
  output logic [DATA_W-1:0]     user_data_in,
  output logic [DATA_W/8-1:0]   user_data_strb,
  output logic                  user_w_r,
  input  logic                  user_free,
  input  logic                  user_stall_w_data,
  input  logic [1:0]            user_status,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SH = $clog2(STRB_W);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d, unbuf_q, unbuf_d, cap, n;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [7:0] len_q, len_d;
  logic [4:0] pops_q, pops_d;
  logic err_q, err_d, stall_q, push, pop, full;
  logic [12:0] room;
  logic [CW-1:0] count;
  // beats left before the next 4KB page, capped by the burst limit and the job remainder
  assign room = (13'(BOUNDARY) - {1'b0, addr_q[11:0]}) >> SH;
  assign cap = (rem_q < 16'(MAX_BURST)) ? rem_q : 16'(MAX_BURST);
  assign n = ({3'b0, room} < cap) ? {3'b0, room} : cap;
  assign s_ready = (state_q != S_IDLE) && !full && (unbuf_q != 16'd0);
  assign push = s_valid && s_ready;
  assign pop = (state_q == S_BEATS) && stall_q && !user_stall_w_data;
  axiburst_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(aclk), .rst(areset), .push(push), .pop(pop), .din(s_data),
    .dout(user_data_in), .count(count), .full(full)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    unbuf_d = push ? unbuf_q - 16'd1 : unbuf_q;
    strb_d = strb_q;
    len_d = len_q;
    pops_d = pops_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (cfg_start) begin
        addr_d = cfg_addr;
        rem_d = cfg_beats;
        unbuf_d = cfg_beats;
        strb_d = cfg_strb;
        err_d = 1'b0;
        state_d = (cfg_beats == 16'd0) ? S_DONE : S_FILL;
      end
      S_FILL: if (16'(count) >= n) begin
        len_d = 8'(n - 16'd1);
        pops_d = '0;
        state_d = S_WAIT_FREE;
      end
      S_WAIT_FREE: state_d = user_free ? S_START : S_WAIT_FREE;
      S_START: state_d = S_BEATS;
      S_BEATS: if (pop) begin
        pops_d = pops_q + 5'd1;
        if (pops_q == len_q[4:0]) begin
          addr_d = addr_q + ((ADDR_W'(len_q) + ADDR_W'(1)) << SH);
          rem_d = rem_q - 16'(len_q) - 16'd1;
          state_d = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: if (user_free) begin
        err_d = err_q | (user_status != 2'd0);
        state_d = (rem_q == 16'd0) ? S_DONE : S_FILL;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge aclk)
    if (areset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      rem_q <= '0;
      unbuf_q <= '0;
      strb_q <= '1;
      len_q <= '0;
      pops_q <= '0;
      err_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      unbuf_q <= unbuf_d;
      strb_q <= strb_d;
      len_q <= len_d;
      pops_q <= pops_d;
      err_q <= err_d;
      stall_q <= user_stall_w_data;
    end
  assign user_start = state_q == S_START;
  assign user_addr_in = addr_q;
  assign user_burst_len_in = len_q;
  assign user_data_strb = strb_q;
  assign user_w_r = 1'b0;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign err = err_q;
endmodule

// File: tb/tb_axiburst_stream_writer.sv
// tb_axiburst_stream_writer: directed jobs checked against a burst-splitting model
module tb_axiburst_stream_writer;
  logic aclk = 0, areset = 1, cfg_start = 0, s_valid = 0, s_ready;
  logic [31:0] cfg_addr = 0, user_addr_in;
  logic [15:0] cfg_beats = 0;
  logic [7:0] cfg_strb = 0, user_data_strb, user_burst_len_in;
  logic [63:0] s_data = 0, user_data_in;
  logic user_start, user_w_r, busy, done, err;
  logic user_free = 1, user_stall_w_data = 0;
  logic [1:0] user_status = 0;
  int checks = 0, errors = 0, cyc = 0, gap = 0, bad_idx = -1, burst_idx = 0;
  int done_cnt = 0, done_cyc = 0, st_cyc = 0, first_start_cyc = 0;
  int push_total = 0, pops_total = 0;
  bit in_burst = 0, done_err = 0;
  logic [7:0] job_strb = 8'hFF;
  logic [31:0] exp_addr[$], obs_addr[$];
  int exp_len[$], obs_len[$];
  logic [63:0] exp_data[$], src[$], obs_d0;

  axiburst_stream_writer dut (
    .aclk(aclk), .areset(areset), .cfg_start(cfg_start), .cfg_addr(cfg_addr),
    .cfg_beats(cfg_beats), .cfg_strb(cfg_strb), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .user_start(user_start), .user_addr_in(user_addr_in),
    .user_burst_len_in(user_burst_len_in), .user_data_in(user_data_in),
    .user_data_strb(user_data_strb), .user_w_r(user_w_r), .user_free(user_free),
    .user_stall_w_data(user_stall_w_data), .user_status(user_status),
    .busy(busy), .done(done), .err(err)
  );

  initial forever #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Expected bursts: greedy split at 16 beats and at every 4KB page edge, 8 bytes per beat
  task automatic model(input logic [31:0] a, input int beats, input int tag);
    logic [31:0] ad;
    logic [63:0] w;
    int rem, room, n;
    ad = a;
    rem = beats;
    obs_addr.delete();
    obs_len.delete();
    for (int i = 0; i < beats; i++) begin
      w = {32'hA5A50000 | 32'(tag), 32'(i)};
      exp_data.push_back(w);
      src.push_back(w);
    end
    while (rem > 0) begin
      room = (4096 - int'(ad[11:0])) / 8;
      n = (rem < 16) ? rem : 16;
      if (room < n) n = room;
      exp_addr.push_back(ad);
      exp_len.push_back(n - 1);
      ad = ad + 32'(n * 8);
      rem -= n;
    end
  endtask

  // Burst master: one accepted beat per stall high/low pair, response when free returns
  initial begin : master
    bit alive;
    int n;
    forever begin
      @(posedge aclk); #1;
      if (user_start) begin
        alive = 1;
        n = int'(user_burst_len_in) + 1;
        user_free = 0;
        for (int i = 0; i < n && alive; i++) begin
          @(posedge aclk); #1;
          alive = busy;
          if (alive) user_stall_w_data = 1;
          @(posedge aclk); #1;
          alive = alive && busy;
          if (alive) user_stall_w_data = 0;
        end
        user_stall_w_data = 0;
        if (alive) begin
          @(posedge aclk); #1;
          user_status = (burst_idx == bad_idx) ? 2'd2 : 2'd0;
          user_free = 1;
          @(posedge aclk); #1;
        end
        user_free = 1;
        user_status = 0;
        burst_idx++;
      end
    end
  end

  initial begin : feeder
    bit acc;
    int wc;
    wc = 0;
    forever begin
      @(negedge aclk);
      acc = s_valid && s_ready;
      @(posedge aclk); #1;
      if (acc && src.size() > 0) begin
        void'(src.pop_front());
        push_total++;
        wc = gap;
      end else if (wc > 0) wc--;
      s_valid = !areset && src.size() > 0 && wc == 0;
      s_data = (src.size() > 0) ? src[0] : 64'd0;
    end
  end

  initial begin : monitor
    bit prev_stall;
    int k, n;
    prev_stall = 0;
    k = 0;
    n = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 0;
        continue;
      end
      chk("w_r_low", user_w_r, 0);
      if (busy) chk("strb_latched", user_data_strb, job_strb);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = err;
      end
      if (user_start) begin
        chk("start_expected", exp_addr.size() != 0, 1);
        if (exp_addr.size() != 0) begin
          n = exp_len[0] + 1;
          chk("burst_addr", user_addr_in, exp_addr.pop_front());
          chk("burst_len", user_burst_len_in, exp_len.pop_front());
          chk("first_beat", user_data_in, exp_data.size() > 0 ? exp_data[0] : 64'hDEAD);
          chk("buffered_before_start", (push_total - pops_total) >= n, 1);
          if (obs_addr.size() == 0) begin
            first_start_cyc = cyc;
            obs_d0 = user_data_in;
          end
          obs_addr.push_back(user_addr_in);
          obs_len.push_back(int'(user_burst_len_in));
          k = 0;
          in_burst = 1;
        end
      end
      if (in_burst && prev_stall && !user_stall_w_data) begin
        pops_total++;
        k++;
        if (exp_data.size() > 0) void'(exp_data.pop_front());
        if (k < n) chk("next_beat", user_data_in, exp_data.size() > 0 ? exp_data[0] : 64'hDEAD);
        else in_burst = 0;
      end
      prev_stall = user_stall_w_data;
    end
  end

  task automatic pulse_start(input logic [31:0] a, input int beats, input logic [7:0] st);
    job_strb = st;
    burst_idx = 0;
    @(posedge aclk); #1;
    cfg_addr = a;
    cfg_beats = 16'(beats);
    cfg_strb = st;
    cfg_start = 1;
    st_cyc = cyc;
    @(posedge aclk); #1;
    cfg_start = 0;
  endtask

  task automatic run_job(input logic [31:0] a, input int beats, input logic [7:0] st,
                         input int g, input int bad, input logic exp_e, input bit poke);
    int d0, t;
    gap = g;
    bad_idx = bad;
    d0 = done_cnt;
    pulse_start(a, beats, st);
    @(negedge aclk);
    chk("busy_on_start", busy, 1);
    chk("err_clear_on_start", err, 0);
    if (poke) begin
      repeat (10) @(posedge aclk);
      #1;
      cfg_addr = 32'h0;
      cfg_beats = 16'd1;
      cfg_strb = 8'h00;
      cfg_start = 1;
      @(posedge aclk); #1;
      cfg_start = 0;
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(negedge aclk);
      t++;
    end
    repeat (3) @(negedge aclk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_idle", busy, 0);
    chk("err_sticky", err, exp_e);
    chk("err_at_done", done_err, exp_e);
    chk("beats_consumed", exp_data.size(), 0);
    chk("bursts_issued", exp_addr.size(), 0);
  endtask

  initial begin : main
    int p0, t;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_start", user_start, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_addr", user_addr_in, 0);
    chk("rst_len", user_burst_len_in, 0);
    chk("rst_data", user_data_in, 0);
    chk("rst_strb", user_data_strb, 8'hFF);
    @(posedge aclk); #1;
    areset = 0;

    model(32'h10000000, 1, 1);
    exp_data[0] = 64'hF8F4F2F1;
    src[0] = 64'hF8F4F2F1;
    run_job(32'h10000000, 1, 8'hFF, 0, -1, 0, 0);
    chk("j1_bursts", obs_addr.size(), 1);
    chk("j1_addr", obs_addr[0], 32'h10000000);
    chk("j1_len", obs_len[0], 0);
    chk("j1_data", obs_d0, 64'hF8F4F2F1);

    model(32'h10000040, 40, 2);
    run_job(32'h10000040, 40, 8'h0F, 0, -1, 0, 0);
    chk("j2_bursts", obs_addr.size(), 3);
    chk("j2_addr0", obs_addr[0], 32'h10000040);
    chk("j2_addr1", obs_addr[1], 32'h100000C0);
    chk("j2_addr2", obs_addr[2], 32'h10000140);
    chk("j2_len0", obs_len[0], 15);
    chk("j2_len1", obs_len[1], 15);
    chk("j2_len2", obs_len[2], 7);

    model(32'h20000FC0, 16, 3);
    run_job(32'h20000FC0, 16, 8'hF0, 0, -1, 0, 0);
    chk("j3_bursts", obs_addr.size(), 2);
    chk("j3_addr0", obs_addr[0], 32'h20000FC0);
    chk("j3_addr1", obs_addr[1], 32'h20001000);
    chk("j3_len0", obs_len[0], 7);
    chk("j3_len1", obs_len[1], 7);

    model(32'h60000000, 16, 4);
    run_job(32'h60000000, 16, 8'h3C, 4, -1, 0, 1);
    chk("j4_bursts", obs_addr.size(), 1);
    chk("j4_len", obs_len[0], 15);
    chk("j4_start_withheld", (first_start_cyc - st_cyc) >= 75, 1);

    model(32'h30000000, 40, 5);
    run_job(32'h30000000, 40, 8'hFF, 0, 1, 1, 0);
    chk("j5_bursts", obs_addr.size(), 3);

    model(32'h70000000, 0, 6);
    run_job(32'h70000000, 0, 8'hAA, 0, -1, 0, 0);
    chk("j6_no_bursts", obs_addr.size(), 0);
    chk("j6_done_latency", done_cyc - st_cyc, 1);

    model(32'hFFFFFFF0, 4, 7);
    run_job(32'hFFFFFFF0, 4, 8'hFF, 0, -1, 0, 0);
    chk("j7_bursts", obs_addr.size(), 2);
    chk("j7_addr1_wrapped", obs_addr[1], 32'h00000000);
    chk("j7_len0", obs_len[0], 1);

    model(32'h40000000, 16, 8);
    gap = 0;
    bad_idx = -1;
    p0 = pops_total;
    pulse_start(32'h40000000, 16, 8'h81);
    t = 0;
    while (pops_total - p0 < 3 && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    chk("three_pops_before_reset", pops_total - p0, 3);
    @(posedge aclk); #1;
    areset = 1;
    src.delete();
    @(posedge aclk); #1;
    areset = 0;
    exp_addr.delete();
    exp_len.delete();
    exp_data.delete();
    in_burst = 0;
    push_total = 0;
    pops_total = 0;
    @(negedge aclk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", user_start, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_data", user_data_in, 0);
    chk("mid_rst_strb", user_data_strb, 8'hFF);
    chk("mid_rst_len", user_burst_len_in, 0);

    model(32'h50000FF8, 1, 9);
    run_job(32'h50000FF8, 1, 8'h55, 0, -1, 0, 0);
    chk("j9_bursts", obs_addr.size(), 1);
    chk("j9_addr", obs_addr[0], 32'h50000FF8);
    chk("j9_data", obs_d0, {32'hA5A50009, 32'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axiburst_stream_writer.md
AXIBURST_STREAM_WRITER -- requirements
Module: axiburst_stream_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 64, data beat width; STRB_W = DATA_W/8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, input buffer depth in beats (power of two, at least 16).
REQ-004 SHALL have ports, one per line:
- aclk  in  1  sole clock, rising edge.
- areset  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; latch cfg_* and begin a job.
- cfg_addr  in  ADDR_W  job base address; bits [2:0] are zero.
- cfg_beats  in  16  total beats in the job, 1..65535; 0 means an empty job.
- cfg_strb  in  STRB_W  strobe applied to every beat of the job.
- s_valid  in  1  input stream word valid.
- s_data  in  DATA_W  input stream word.
- s_ready  out  1  FIFO not full and job active.
- user_start  out  1  burst-master start pulse.
- user_addr_in  out  ADDR_W  burst address.
- user_burst_len_in  out  8  beats-1.
- user_data_in  out  DATA_W  current write beat (FIFO head).
- user_data_strb  out  STRB_W  equals latched cfg_strb.
- user_w_r  out  1  constant 0 (write).
- user_free  in  1  burst master idle.
- user_stall_w_data  in  1  master holding the current beat.
- user_status  in  2  master response code; 0 = OKAY.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky; any non-zero user_status during the job.

Function
REQ-005 SHALL run the FSM states IDLE, FILL, WAIT_FREE, START, BEATS, WAIT_RESP, DONE.
REQ-006 IDLE: on cfg_start, SHALL latch addr/beats/strb, clear err, and go to FILL; cfg_start outside IDLE SHALL be ignored.
REQ-007 cfg_beats==0 SHALL go directly to DONE (no bursts issued, done pulses one cycle later).
REQ-008 Burst length SHALL be n = min(16, remaining, (4096 - addr[11:0])/STRB_W), so no burst crosses a 4 KB boundary.
REQ-009 FILL SHALL go to WAIT_FREE once FIFO count >= n.
REQ-010 WAIT_FREE SHALL go to START on the first cycle user_free==1.
REQ-011 START SHALL drive user_start=1 for exactly one cycle, with user_addr_in=addr, user_burst_len_in=n-1, and user_data_in=FIFO head, all stable from that cycle onward.
REQ-012 BEATS: each falling edge of user_stall_w_data (registered 1 and current 0) SHALL pop one FIFO word; user_data_in SHALL show the new head in that same cycle.
REQ-013 After the n-th pop, SHALL set addr += n*STRB_W and remaining -= n, then go to WAIT_RESP.
REQ-014 WAIT_RESP: when user_free==1, SHALL OR (user_status!=0) into err, then go to DONE if remaining==0, else FILL.
REQ-015 A push and a pop in the same cycle SHALL leave the count unchanged; s_ready SHALL be 0 when the FIFO is full.
REQ-016 The FIFO SHALL only accept a number of words equal to the job's remaining un-buffered beats; s_ready SHALL deassert once all job beats are buffered.
REQ-017 busy SHALL be 1 in every state except IDLE; DONE SHALL pulse done and return to IDLE.
REQ-018 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-019 areset SHALL, at any state including mid-burst, return the FSM to IDLE, empty the FIFO, and zero all outputs except user_data_strb, which SHALL be all-ones.
REQ-020 The next job after a mid-burst reset SHALL start cleanly from cfg_start.

Structure
REQ-021 ADDR_W/DATA_W defaults, the 4 KB constant, MAX_BURST=16 and the state enum SHALL live in package axiburst_pkg.
REQ-022 The FIFO SHALL be sub-module axiburst_sync_fifo (show-ahead, count output).

Verification
REQ-023 Job addr 0x10000000, 1 beat, data 0xF8F4F2F1, strb 0xFF -> one burst with len 0; done; err 0.
REQ-024 Job addr 0x10000040, 40 beats -> bursts of 16/16/8 at 0x10000040/0x100000C0/0x10000140; data order preserved.
REQ-025 Job addr 0x20000FC0, 16 beats -> bursts of 8 at 0x20000FC0 and 8 at 0x20001000.
REQ-026 s_valid trickling 1 word per 5 cycles, 16 beats -> user_start withheld until 16 words are buffered.
REQ-027 user_status=2 on the 2nd of 3 bursts -> err=1, sticky through done; cleared by the next cfg_start.
REQ-028 areset asserted after 3 pops of a 16-beat burst -> busy=0, FIFO empty, user_start=0; a following 1-beat job completes correctly.
